// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with registered one-hot grant, encoded
// owner index and an optional per-grant hold limit that forces a release.
module rr_arbiter8 #(
    parameter int N        = 8,
    parameter int IDXW     = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            gnt_valid,
    output logic            timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam bit         HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [7:0] HOLD_LAST = HOLD_EN ? 8'(MAX_HOLD - 1) : 8'd0;

    state_t          state_q, state_d;
    logic [IDXW-1:0] ptr_q, ptr_d;
    logic [7:0]      hold_q, hold_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            timeout_q, timeout_d;
    logic            rel;

    // First set request scanning upward from p; the index wraps naturally
    // because N == 2**IDXW.
    function automatic logic [IDXW-1:0] pick_next(input logic [N-1:0]    r,
                                                  input logic [IDXW-1:0] p);
        logic [IDXW-1:0] j;
        pick_next = p;
        for (int i = N - 1; i >= 0; i--) begin
            j = p + IDXW'(i);
            if (r[j]) pick_next = j;
        end
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            hold_q    <= '0;
            gnt_q     <= '0;
            idx_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            gnt_q     <= gnt_d;
            idx_q     <= idx_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        timeout_d = 1'b0;
        rel       = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    idx_d   = pick_next(req, ptr_q);
                    gnt_d   = N'(1) << idx_d;
                    hold_d  = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // A voluntary drop takes precedence over the hold limit.
                if (!req[idx_q]) begin
                    rel = 1'b1;
                end else if (HOLD_EN && (hold_q == HOLD_LAST)) begin
                    rel       = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rel) begin
            gnt_d   = '0;
            idx_d   = '0;
            hold_d  = '0;
            state_d = IDLE;
            ptr_d   = idx_q + IDXW'(1);
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = (state_q == GRANT);
    assign timeout   = timeout_q;

endmodule
